// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, imem request/response, small instruction FIFO, IF/ID output register.
// Optional FETCH_PERF_CNT_EN adds delivered-instruction and stall-cycle counters.
module fetch_stage #(
  parameter int unsigned          REGI_SIZE  = 16,
  parameter int unsigned          PC_BITS    = 10,
  parameter int unsigned          FIFO_DEPTH = 2,
  parameter logic [PC_BITS-1:0]   RESET_PC   = '0,
  parameter logic [REGI_SIZE-1:0] NOP_INSTR  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [PC_BITS-1:0]   redirect_addr_i,
  input  logic                 halt_i,
  output logic                 imem_req_o,
  output logic [PC_BITS-1:0]   imem_addr_o,
  input  logic                 imem_ready_i,
  input  logic                 imem_rvalid_i,
  input  logic [REGI_SIZE-1:0] imem_rdata_i,
  output logic [REGI_SIZE-1:0] instr_o,
  output logic [REGI_SIZE-1:0] next_pc_o,
  output logic                 instr_valid_o,
  output logic                 halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_HALT} state_t;

  state_t               r_state;
  logic [PC_BITS-1:0]   r_pc;
  logic [PC_BITS-1:0]   r_req_pc;
  logic                 r_drop;
  logic                 r_halt_pend;
  logic [REGI_SIZE-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PC_BITS-1:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [REGI_SIZE-1:0] r_instr;
  logic [REGI_SIZE-1:0] r_next_pc;
  logic                 r_valid;
  logic                 r_halted;

  logic                 w_space;
  logic                 w_req;
  logic                 w_accept;
  logic                 w_keep;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_bypass;
  logic                 w_push;
  logic [REGI_SIZE-1:0] w_head_data;
  logic [PC_BITS-1:0]   w_head_pc;
  logic [PC_BITS-1:0]   w_head_pc_inc;
  logic [PC_BITS-1:0]   w_req_pc_inc;

  // Issue only in FETCH (nothing outstanding there) when the FIFO can absorb the response.
  assign w_space       = r_count < CNT_W'(FIFO_DEPTH);
  assign w_req         = (r_state == ST_FETCH) && w_space && !halt_i && !redirect_i;
  assign w_accept      = w_req && imem_ready_i;
  assign w_keep        = (r_state == ST_WAIT) && imem_rvalid_i && !r_drop && !redirect_i;
  assign w_empty       = (r_count == '0);
  assign w_pop         = !stall_i && !w_empty && !redirect_i;
  assign w_bypass      = !stall_i && w_empty && w_keep;
  assign w_push        = w_keep && !w_bypass;
  assign w_head_data   = r_fifo_data[r_rd_ptr];
  assign w_head_pc     = r_fifo_pc[r_rd_ptr];
  assign w_head_pc_inc = w_head_pc + PC_BITS'(1);
  assign w_req_pc_inc  = r_req_pc + PC_BITS'(1);

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_pc;
  assign instr_o       = r_instr;
  assign next_pc_o     = r_next_pc;
  assign instr_valid_o = r_valid;
  assign halted_o      = r_halted;

  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rdata_i;
      r_fifo_pc[r_wr_ptr]   <= r_req_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_drop      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_instr     <= NOP_INSTR;
      r_next_pc   <= '0;
      r_valid     <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (redirect_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end

      // IF/ID register: FIFO head first, else same-cycle bypass of a fresh response.
      if (redirect_i) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else if (!stall_i) begin
        if (w_pop) begin
          r_instr   <= w_head_data;
          r_next_pc <= REGI_SIZE'(w_head_pc_inc);
          r_valid   <= 1'b1;
        end else if (w_bypass) begin
          r_instr   <= imem_rdata_i;
          r_next_pc <= REGI_SIZE'(w_req_pc_inc);
          r_valid   <= 1'b1;
        end else begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
        end
      end

      // A redirect with a response still in flight stays in WAIT and discards it.
      if (redirect_i) begin
        r_pc        <= redirect_addr_i;
        r_halt_pend <= 1'b0;
        r_halted    <= 1'b0;
        if ((r_state == ST_WAIT) && !imem_rvalid_i) begin
          r_drop <= 1'b1;
        end else begin
          r_drop  <= 1'b0;
          r_state <= ST_FETCH;
        end
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_FETCH;
          ST_FETCH: begin
            if (halt_i) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else if (w_accept) begin
              r_pc     <= r_pc + PC_BITS'(1);
              r_req_pc <= r_pc;
              r_state  <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid_i) begin
              r_drop      <= 1'b0;
              r_halt_pend <= 1'b0;
              if (r_halt_pend || halt_i) begin
                r_state  <= ST_HALT;
                r_halted <= 1'b1;
              end else begin
                r_state <= ST_FETCH;
              end
            end else if (halt_i) begin
              r_halt_pend <= 1'b1;
            end
          end
          ST_HALT: r_state <= ST_HALT;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (!redirect_i && (w_pop || w_bypass) && (r_perf_fetched != 32'hFFFF_FFFF))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (stall_i && r_valid && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched_o = r_perf_fetched;
  assign perf_stall_o   = r_perf_stall;
`endif

endmodule
